fir_ctrl_regs: RTL and testbench
================================

# fir_ctrl_regs

Parametrised control/status register bank for the FIR accelerator, clocked in the `clk_b` domain behind the CDC write path. It replaces level-style START/DONE handling with a one-cycle START pulse, a sticky DONE with write-1-to-clear, and a run FSM. It also adds configuration validation, error flags, an interrupt output and a completed-run counter.

## Interface

Parameters:
- `DATA_W`, 16: register/bus width.
- `ADDR_W`, 3: register index width (8 slots).
- `WSP_W`, 6: coefficient-count field width.
- `PROBEK_W`, 14: sample-count field width.
- `MAX_WSP`, 32: largest legal coefficient count.

Ports (one clock; reset is synchronous and active-high):
- `clk_b` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `CDC_data` in DATA_W: write data.
- `nr_Rejestru` in ADDR_W: register index, used for both write and read.
- `wr_Rej` in 1: write strobe, one cycle per write.
- `Rej_out` out DATA_W: registered read data for `nr_Rejestru`.
- `Start` out 1: one-cycle start pulse to the FIR FSM.
- `Pracuje` in 1: datapath busy level.
- `DONE` in 1: datapath completion pulse, one cycle.
- `Ile_wsp` out WSP_W: coefficient count.
- `Ile_probek` out PROBEK_W: sample count.
- `Irq` out 1: `done_sticky & irq_en`, registered.

## Operation

Register map (index: write / read):
- 0: write bit0=1 requests a start / read {0, run_active}.
- 1: write bit0=1 clears DONE (W1C) / read {0, done_sticky}.
- 2: read-only / read {0, Pracuje}.
- 3: write Ile_wsp / read zero-extended Ile_wsp.
- 4: write Ile_probek / read zero-extended Ile_probek.
- 5: write bit0 = irq_en / read {0, irq_en}.
- 6: read-only / read run_cnt (DATA_W, wraps to 0 after all-ones).
- 7: write W1C on err[2:0] / read {0, err[2:0]}.

Error bits:
- err[0] BAD_CFG: start requested with Ile_wsp==0, Ile_probek==0, or Ile_wsp>MAX_WSP.
- err[1] START_BUSY: start requested while not IDLE.
- err[2] CFG_BUSY: write to index 3, 4 or 5 while not IDLE.

FSM states are IDLE, PULSE, RUN.
- IDLE: a start request with valid config clears done_sticky and moves to PULSE. A start request with invalid config sets err[0] and stays IDLE.
- PULSE: `Start`=1 for this cycle only. Next state is RUN.
- RUN: `DONE`=1 sets done_sticky, increments run_cnt and moves to IDLE.
- run_active = (state != IDLE).

Write and error rules:
- Config writes (index 3, 4, 5) are applied only in IDLE. Outside IDLE they are dropped and set err[2].
- A start request outside IDLE is dropped and sets err[1]; `Start` does not re-pulse.
- Writes to read-only indices (2, 6) are ignored.
- `DONE` in IDLE or PULSE is ignored: no flag change, no count.

Simultaneous events:
- Set beats clear. DONE in the same cycle as a W1C on index 1 leaves done_sticky=1.
- The same holds for an error event coinciding with a W1C on index 7.

Reset values: `Start` 0, `Rej_out` 0, `Ile_wsp` 0, `Ile_probek` 0, `Irq` 0, irq_en 0, done_sticky 0, err 0, run_cnt 0, state IDLE. Reset in any state, including mid-RUN, returns to this state at the next edge. `Start` never pulses out of reset.

## Timing

- Write at edge n: the register updates at n+1. `Ile_wsp` and `Ile_probek` outputs are the registers themselves, so they are valid at n+1.
- Start write at edge n (valid config, IDLE): `Start`=1 during cycle n+1, then 0 from n+2. run_active reads 1 from n+1.
- `DONE` sampled at edge m in RUN: done_sticky=1, state IDLE and run_cnt+1 are visible after m. `Irq` rises one cycle later.
- Read latency: `Rej_out` reflects `nr_Rejestru` and register state sampled at the previous edge, i.e. 1 cycle.
- Back-to-back runs: a start write is accepted on the cycle after DONE returns the FSM to IDLE.

## Structure

- Package `fir_regs_pkg` holds:
  - register index localparams (REG_START … REG_ERR);
  - error bit positions;
  - `typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_RUN} run_state_t`.
- One natural sub-module, `w1c_flag`: a sticky bit with set-priority over W1C clear. It is instantiated for done_sticky and for each err bit.

## Test plan

- Reset, then read all 8 indices: every read returns 0 and `Start`/`Irq` stay 0.
- Write idx3=8, idx4=100, idx5=1, then idx0=1:
  - `Start` is high for exactly 1 cycle;
  - idx0 reads 1;
  - `DONE` pulse → idx1=1, idx6=1, `Irq`=1 one cycle later;
  - W1C idx1 → `Irq`=0.
- idx3=0 then idx0=1: no `Start`, idx7 reads 1. idx3=33 (>MAX_WSP) then idx0=1 gives the same result. W1C idx7=1 clears it to 0.
- During RUN:
  - write idx3=4 → `Ile_wsp` unchanged, err[2] set;
  - write idx0=1 → no second `Start`, err[1] set.
- In the same cycle, `DONE` and W1C on idx1: done_sticky=1. `DONE` while IDLE: run_cnt unchanged.
- Assert `rst` mid-RUN: all outputs 0 and state IDLE. Then `DONE`: no count. Then a fresh start works normally.

Source files
------------

// File: rtl/fir_regs_pkg.sv
// Shared register map, error bit positions and run-FSM state type for the
// FIR accelerator control/status register bank.
package fir_regs_pkg;

    localparam int REG_START   = 0;
    localparam int REG_DONE    = 1;
    localparam int REG_BUSY    = 2;
    localparam int REG_WSP     = 3;
    localparam int REG_PROBEK  = 4;
    localparam int REG_IRQ_EN  = 5;
    localparam int REG_RUN_CNT = 6;
    localparam int REG_ERR     = 7;

    localparam int ERR_BAD_CFG    = 0;
    localparam int ERR_START_BUSY = 1;
    localparam int ERR_CFG_BUSY   = 2;
    localparam int ERR_W          = 3;

    typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_RUN} run_state_t;

endpackage

// File: rtl/fir_ctrl_regs_w1c_flag.sv
// Sticky status bit: set by a hardware event, cleared by software write-1,
// with the set winning when both arrive in the same cycle.
module w1c_flag (
    input  logic clk,
    input  logic srst,
    input  logic i_set,
    input  logic i_clr,
    output logic o_flag
);

    logic r_flag;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_flag <= 1'b0;
        end else if (i_set) begin
            r_flag <= 1'b1;
        end else if (i_clr) begin
            r_flag <= 1'b0;
        end
    end

    assign o_flag = r_flag;

endmodule

// File: rtl/fir_ctrl_regs.sv
// FIR control/status register bank: start pulse, sticky DONE, config checks,
// error flags, interrupt and completed-run counter behind a small run FSM.
module fir_ctrl_regs
    import fir_regs_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int WSP_W    = 6,
    parameter int PROBEK_W = 14,
    parameter int MAX_WSP  = 32
) (
    input  logic                clk_b,
    input  logic                rst,
    input  logic [DATA_W-1:0]   CDC_data,
    input  logic [ADDR_W-1:0]   nr_Rejestru,
    input  logic                wr_Rej,
    output logic [DATA_W-1:0]   Rej_out,
    output logic                Start,
    input  logic                Pracuje,
    input  logic                DONE,
    output logic [WSP_W-1:0]    Ile_wsp,
    output logic [PROBEK_W-1:0] Ile_probek,
    output logic                Irq
);

    localparam int N_REGS = 1 << ADDR_W;

    run_state_t            r_state;
    logic [WSP_W-1:0]      r_ile_wsp;
    logic [PROBEK_W-1:0]   r_ile_probek;
    logic                  r_irq_en;
    logic                  r_start;
    logic                  r_irq;
    logic [DATA_W-1:0]     r_run_cnt;
    logic [DATA_W-1:0]     r_rej_out;

    logic [N_REGS-1:0]     w_sel;
    logic                  w_idle;
    logic                  w_start_req;
    logic                  w_cfg_wr;
    logic                  w_cfg_ok;
    logic                  w_start_go;
    logic                  w_run_done;
    logic                  w_done_clr;
    logic                  w_done_sticky;
    logic [ERR_W-1:0]      w_err;
    logic [ERR_W-1:0]      w_err_set;
    logic [ERR_W-1:0]      w_err_clr;
    logic [DATA_W-1:0]     w_rd_data;

    genvar gi;
    generate
        for (gi = 0; gi < N_REGS; gi++) begin : g_sel
            assign w_sel[gi] = wr_Rej && (nr_Rejestru == ADDR_W'(gi));
        end
    endgenerate

    assign w_idle      = (r_state == ST_IDLE);
    assign w_start_req = w_sel[REG_START] && CDC_data[0];
    assign w_cfg_wr    = w_sel[REG_WSP] || w_sel[REG_PROBEK] || w_sel[REG_IRQ_EN];
    assign w_cfg_ok    = (r_ile_wsp != '0) && (r_ile_probek != '0)
                         && (32'(r_ile_wsp) <= 32'(MAX_WSP));
    assign w_start_go  = w_idle && w_start_req && w_cfg_ok;
    assign w_run_done  = (r_state == ST_RUN) && DONE;
    // A fresh accepted run also retires the previous completion flag.
    assign w_done_clr  = (w_sel[REG_DONE] && CDC_data[0]) || w_start_go;

    assign w_err_set[ERR_BAD_CFG]    = w_idle && w_start_req && !w_cfg_ok;
    assign w_err_set[ERR_START_BUSY] = !w_idle && w_start_req;
    assign w_err_set[ERR_CFG_BUSY]   = !w_idle && w_cfg_wr;

    w1c_flag u_done_flag (
        .clk    (clk_b),
        .srst   (rst),
        .i_set  (w_run_done),
        .i_clr  (w_done_clr),
        .o_flag (w_done_sticky)
    );

    generate
        for (gi = 0; gi < ERR_W; gi++) begin : g_err
            assign w_err_clr[gi] = w_sel[REG_ERR] && CDC_data[gi];
            w1c_flag u_err_flag (
                .clk    (clk_b),
                .srst   (rst),
                .i_set  (w_err_set[gi]),
                .i_clr  (w_err_clr[gi]),
                .o_flag (w_err[gi])
            );
        end
    endgenerate

    always_comb begin
        w_rd_data = '0;
        case (nr_Rejestru)
            ADDR_W'(REG_START):   w_rd_data[0] = !w_idle;
            ADDR_W'(REG_DONE):    w_rd_data[0] = w_done_sticky;
            ADDR_W'(REG_BUSY):    w_rd_data[0] = Pracuje;
            ADDR_W'(REG_WSP):     w_rd_data = DATA_W'(r_ile_wsp);
            ADDR_W'(REG_PROBEK):  w_rd_data = DATA_W'(r_ile_probek);
            ADDR_W'(REG_IRQ_EN):  w_rd_data[0] = r_irq_en;
            ADDR_W'(REG_RUN_CNT): w_rd_data = r_run_cnt;
            ADDR_W'(REG_ERR):     w_rd_data[ERR_W-1:0] = w_err;
            default:              w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_b) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_start      <= 1'b0;
            r_ile_wsp    <= '0;
            r_ile_probek <= '0;
            r_irq_en     <= 1'b0;
            r_run_cnt    <= '0;
            r_irq        <= 1'b0;
            r_rej_out    <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_go) begin
                        r_state <= ST_PULSE;
                        r_start <= 1'b1;
                    end
                end
                ST_PULSE: r_state <= ST_RUN;
                ST_RUN: begin
                    if (DONE) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Configuration is frozen while a run is in flight.
            if (w_idle) begin
                if (w_sel[REG_WSP]) begin
                    r_ile_wsp <= CDC_data[WSP_W-1:0];
                end
                if (w_sel[REG_PROBEK]) begin
                    r_ile_probek <= CDC_data[PROBEK_W-1:0];
                end
                if (w_sel[REG_IRQ_EN]) begin
                    r_irq_en <= CDC_data[0];
                end
            end

            if (w_run_done) begin
                r_run_cnt <= r_run_cnt + DATA_W'(1);
            end

            r_irq     <= w_done_sticky && r_irq_en;
            r_rej_out <= w_rd_data;
        end
    end

    assign Start      = r_start;
    assign Irq        = r_irq;
    assign Rej_out    = r_rej_out;
    assign Ile_wsp    = r_ile_wsp;
    assign Ile_probek = r_ile_probek;

endmodule

// File: tb/tb_fir_ctrl_regs.sv
// Randomised plus directed bench for fir_ctrl_regs; a spec-level model feeds
// a per-cycle expectation queue that an independent monitor drains.
module tb_fir_ctrl_regs;

    logic        clk_b = 1'b0;
    logic        rst;
    logic [15:0] CDC_data;
    logic [2:0]  nr_Rejestru;
    logic        wr_Rej;
    logic [15:0] Rej_out;
    logic        Start;
    logic        Pracuje;
    logic        DONE;
    logic [5:0]  Ile_wsp;
    logic [13:0] Ile_probek;
    logic        Irq;

    fir_ctrl_regs dut (
        .clk_b       (clk_b),
        .rst         (rst),
        .CDC_data    (CDC_data),
        .nr_Rejestru (nr_Rejestru),
        .wr_Rej      (wr_Rej),
        .Rej_out     (Rej_out),
        .Start       (Start),
        .Pracuje     (Pracuje),
        .DONE        (DONE),
        .Ile_wsp     (Ile_wsp),
        .Ile_probek  (Ile_probek),
        .Irq         (Irq)
    );

    always #5 clk_b = ~clk_b;

    typedef struct {
        int          tag;
        logic [15:0] rd;
        logic        start;
        logic        irq;
        logic [5:0]  wsp;
        logic [13:0] probek;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   verbose  = 1'b1;

    // Reference model: "phase" is 0 idle, 1 start just issued, 2 running.
    int          m_phase;
    bit          m_done;
    bit [2:0]    m_err;
    int          m_wsp;
    int          m_probek;
    bit          m_irq_en;
    int          m_cnt;
    int          tag_cnt = 0;

    task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s txn=%0d actual=0x%0h required=0x%0h", nm, tag, act, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input int idx, input bit pr);
        case (idx)
            0: return (m_phase != 0) ? 16'd1 : 16'd0;
            1: return {15'd0, m_done};
            2: return {15'd0, pr};
            3: return 16'(m_wsp);
            4: return 16'(m_probek);
            5: return {15'd0, m_irq_en};
            6: return 16'(m_cnt);
            default: return {13'd0, m_err};
        endcase
    endfunction

    task automatic cyc(input bit r, input bit w, input int idx, input int d, input bit dn);
        exp_t e;
        bit   pr, start_req, cfg_wr, cfg_ok, go, done_set;
        bit [2:0] eset;
        @(negedge clk_b);
        pr          = 1'($urandom_range(0, 1));
        rst         = r;
        wr_Rej      = w;
        nr_Rejestru = 3'(idx);
        CDC_data    = 16'(d);
        DONE        = dn;
        Pracuje     = pr;
        e.tag = tag_cnt++;
        if (r) begin
            m_phase = 0; m_done = 0; m_err = 0; m_wsp = 0; m_probek = 0;
            m_irq_en = 0; m_cnt = 0;
            e.rd = 0; e.start = 0; e.irq = 0;
        end else begin
            e.rd  = model_read(idx, pr);
            e.irq = m_done && m_irq_en;
            start_req = w && idx == 0 && d[0];
            cfg_wr    = w && (idx == 3 || idx == 4 || idx == 5);
            cfg_ok    = m_wsp != 0 && m_probek != 0 && m_wsp <= 32;
            go        = m_phase == 0 && start_req && cfg_ok;
            done_set  = m_phase == 2 && dn;
            eset[0]   = m_phase == 0 && start_req && !cfg_ok;
            eset[1]   = m_phase != 0 && start_req;
            eset[2]   = m_phase != 0 && cfg_wr;
            if (done_set) m_done = 1;
            else if ((w && idx == 1 && d[0]) || go) m_done = 0;
            for (int i = 0; i < 3; i++) begin
                if (eset[i]) m_err[i] = 1;
                else if (w && idx == 7 && d[i]) m_err[i] = 0;
            end
            if (done_set) m_cnt = (m_cnt + 1) % 65536;
            if (m_phase == 0 && w) begin
                if (idx == 3) m_wsp = d % 64;
                if (idx == 4) m_probek = d % 16384;
                if (idx == 5) m_irq_en = d[0];
            end
            if (go) m_phase = 1;
            else if (m_phase == 1) m_phase = 2;
            else if (done_set) m_phase = 0;
            e.start = go;
        end
        e.wsp    = 6'(m_wsp);
        e.probek = 14'(m_probek);
        sb.push_back(e);
    endtask

    // Monitor: one expectation per clock, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_b);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rej_out", e.tag, 32'(Rej_out), 32'(e.rd));
                chk("start", e.tag, 32'(Start), 32'(e.start));
                chk("irq", e.tag, 32'(Irq), 32'(e.irq));
                chk("ile_wsp", e.tag, 32'(Ile_wsp), 32'(e.wsp));
                chk("ile_probek", e.tag, 32'(Ile_probek), 32'(e.probek));
                if (verbose)
                    $display("txn %0d: idx=%0d rd=0x%0h start=%0b irq=%0b wsp=%0d probek=%0d",
                             e.tag, nr_Rejestru, Rej_out, Start, Irq, Ile_wsp, Ile_probek);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog txn=%0d actual=timeout required=finish", tag_cnt);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx, d;
        rst = 1; wr_Rej = 0; nr_Rejestru = 0; CDC_data = 0; DONE = 0; Pracuje = 0;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, i, 0, 0);
        // Nominal run with interrupt.
        cyc(0, 1, 3, 8, 0);
        cyc(0, 1, 4, 100, 0);
        cyc(0, 1, 5, 1, 0);
        cyc(0, 1, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 6, 0, 0);
        cyc(0, 1, 1, 1, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        // Invalid configurations.
        cyc(0, 1, 3, 0, 0);
        cyc(0, 1, 0, 1, 0);
        cyc(0, 0, 7, 0, 0);
        cyc(0, 0, 7, 0, 0);
        cyc(0, 1, 3, 33, 0);
        cyc(0, 1, 0, 1, 0);
        cyc(0, 0, 7, 0, 0);
        cyc(0, 1, 7, 7, 0);
        cyc(0, 0, 7, 0, 0);
        cyc(0, 0, 7, 0, 0);
        // Busy-time writes, then DONE colliding with W1C, then DONE in idle.
        cyc(0, 1, 3, 8, 0);
        cyc(0, 1, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 3, 4, 0);
        cyc(0, 1, 0, 1, 0);
        cyc(0, 0, 7, 0, 0);
        cyc(0, 1, 1, 1, 1);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 6, 0, 1);
        cyc(0, 0, 6, 0, 0);
        cyc(0, 1, 7, 7, 0);
        // Reset mid-run, stray DONE, then a fresh run.
        cyc(0, 1, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 6, 0, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 3, 5, 0);
        cyc(0, 1, 4, 7, 0);
        cyc(0, 1, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 6, 0, 1);
        cyc(0, 1, 0, 1, 0);
        cyc(0, 0, 6, 0, 0);
        verbose = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            idx = int'($urandom_range(0, 7));
            case (idx)
                3: d = int'($urandom_range(0, 40));
                4: d = int'($urandom_range(0, 3)) | (int'($urandom_range(0, 1)) << 13);
                default: d = int'($urandom_range(0, 65535));
            endcase
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 1) == 1), idx, d,
                ($urandom_range(0, 3) == 0));
        end
        cyc(0, 0, 6, 0, 0);
        @(posedge clk_b);
        #2;
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain actual=%0d required=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
